alex_filter_spi: RTL and testbench

ALEX_FILTER_SPI -- requirements
Module: alex_filter_spi

---
 rtl/alex_filter_spi_pkg.sv | 32 +++
 rtl/alex_filter_spi_bit_timer.sv | 34 +++
 rtl/alex_filter_spi.sv | 123 ++++++++++++
 tb/tb_alex_filter_spi.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alex_filter_spi_pkg.sv
// Shared definitions for the Alex filter-board SPI serializer.
//   - Frame width and the bit positions of the ctrl, LPF and HPF fields
//   - FSM state encodings
//   - pack_frame(): builds the frame in its on-wire order
package alex_filter_spi_pkg;

    localparam int FRAME_W  = 16;
    localparam int CTRL_MSB = 15;   // ctrl occupies [15:13]
    localparam int LPF_MSB  = 12;   // LPF  occupies [12:6]
    localparam int HPF_MSB  = 5;    // HPF  occupies [5:0]

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLK_LO = 3'd1;
    localparam logic [2:0] ST_CLK_HI = 3'd2;
    localparam logic [2:0] ST_LOAD   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    // Bit 15 goes out first, so ctrl leads the frame and HPF trails it.
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [2:0] ctrl,
        input logic [6:0] lpf,
        input logic [5:0] hpf
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[CTRL_MSB -: 3] = ctrl;
        f[LPF_MSB  -: 7] = lpf;
        f[HPF_MSB  -: 6] = hpf;
        return f;
    endfunction

endpackage

// File: rtl/alex_filter_spi_bit_timer.sv
// Half-bit timer for the filter SPI serializer.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   load    : reload the counter to CLK_DIV-1 (asserted on every state entry)
//   tc      : high on the last cycle of the current half-bit period
module spi_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    output logic tc
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // NOTE: the reset sits in the sensitivity list so it takes effect without a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    // The count runs CLK_DIV-1 down to 0, so every state lasts exactly CLK_DIV cycles.
    assign tc = (count == '0);

endmodule

// File: rtl/alex_filter_spi.sv
// Serializes the band decoder's HPF/LPF/ctrl selections to the Alex filter
// board over a three-wire SPI link. A frame is sent after reset, whenever the
// registered selection differs from the last frame sent, or on request.
//   clock     : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   HPF[5:0]  : one-hot high-pass select
//   LPF[6:0]  : one-hot low-pass select
//   ctrl[2:0] : relay/attenuator control bits
//   force_req : resend the current frame (sampled only while idle)
//   spi_clk   : serial clock, idle low, slave samples on the rising edge
//   spi_data  : serial data, MSB first
//   spi_load  : latch strobe, active high
//   busy      : high while a frame is in progress
module alex_filter_spi #(
    parameter int CLK_DIV = 4,
    parameter int FRAME_W = alex_filter_spi_pkg::FRAME_W
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] HPF,
    input  logic [6:0] LPF,
    input  logic [2:0] ctrl,
    input  logic       force_req,
    output logic       spi_clk,
    output logic       spi_data,
    output logic       spi_load,
    output logic       busy
);

    import alex_filter_spi_pkg::*;

    localparam int BW = $clog2(FRAME_W);

    logic [2:0]         state, state_n;
    logic [FRAME_W-1:0] frame_q, last_sent;
    logic [FRAME_W-1:0] shift_q, shift_n;
    logic [BW-1:0]      bit_cnt, bit_cnt_n;
    logic               sent_valid;
    logic               q_valid;    // frame_q holds a real sample (one cycle after reset)
    logic               start;
    logic               tc;

    spi_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (state_n != state),
        .tc      (tc)
    );

    // Waiting for q_valid keeps the unconditional post-reset frame from
    // going out with the all-zero reset contents of frame_q.
    assign start = q_valid && (!sent_valid || (frame_q != last_sent) || force_req);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n   = state;
        shift_n   = shift_q;
        bit_cnt_n = bit_cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_CLK_LO;
                    shift_n   = frame_q;
                    bit_cnt_n = BW'(FRAME_W - 1);
                end
            end
            ST_CLK_LO: begin
                if (tc) state_n = ST_CLK_HI;
            end
            ST_CLK_HI: begin
                if (tc) begin
                    if (bit_cnt == '0) begin
                        state_n = ST_LOAD;
                    end else begin
                        state_n   = ST_CLK_LO;
                        shift_n   = shift_q << 1;
                        bit_cnt_n = bit_cnt - BW'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (tc) state_n = ST_GAP;
            end
            ST_GAP: begin
                if (tc) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Serial outputs are decoded from the next state and registered, so they
    // change on the same edge as the state register and never glitch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            frame_q    <= '0;
            last_sent  <= '0;
            shift_q    <= '0;
            bit_cnt    <= '0;
            sent_valid <= 1'b0;
            q_valid    <= 1'b0;
            spi_clk    <= 1'b0;
            spi_data   <= 1'b0;
            spi_load   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            bit_cnt <= bit_cnt_n;
            frame_q <= pack_frame(ctrl, LPF, HPF);
            q_valid <= 1'b1;
            if (state == ST_IDLE && start) begin
                last_sent  <= frame_q;
                sent_valid <= 1'b1;
            end
            spi_clk  <= (state_n == ST_CLK_HI);
            spi_data <= ((state_n == ST_CLK_LO) || (state_n == ST_CLK_HI)) && shift_n[FRAME_W-1];
            spi_load <= (state_n == ST_LOAD);
            busy     <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_alex_filter_spi.sv
module tb_alex_filter_spi;

    localparam int CLK_DIV      = 4;
    localparam int FRAME_CYCLES = (2 * 16 + 2) * CLK_DIV;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] hpf;
    logic [6:0] lpf;
    logic [2:0] ctrl;
    logic       force_req;
    logic       spi_clk, spi_data, spi_load, busy;

    always #5 clock = ~clock;

    alex_filter_spi #(.CLK_DIV(CLK_DIV), .FRAME_W(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .HPF       (hpf),
        .LPF       (lpf),
        .ctrl      (ctrl),
        .force_req (force_req),
        .spi_clk   (spi_clk),
        .spi_data  (spi_data),
        .spi_load  (spi_load),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: frames the stimulus expects, in order.
    logic [15:0] exp_q[$];
    int frames_rx = 0;
    int clk_rises = 0;
    int nbits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scope model: shifts data in on spi_clk rises, compares on spi_load rise.
    initial begin
        logic        prev_clk;
        logic        prev_load;
        logic [15:0] cap;
        int          load_cycles;
        prev_clk = 0; prev_load = 0; cap = '0; load_cycles = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_clk = 0; prev_load = 0; cap = '0; nbits = 0; load_cycles = 0;
            end else begin
                if (spi_clk && !prev_clk) begin
                    cap = {cap[14:0], spi_data};
                    nbits++;
                    clk_rises++;
                end
                if (spi_load) load_cycles++;
                if (spi_load && !prev_load) begin
                    frames_rx++;
                    check("frame_bits", nbits, 16);
                    check("frame_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("frame_value", cap, exp_q.pop_front());
                end
                if (!spi_load && prev_load) begin
                    check("load_width", load_cycles, CLK_DIV);
                    load_cycles = 0;
                    nbits = 0;
                end
                prev_clk  = spi_clk;
                prev_load = spi_load;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string name);
        int n = 0;
        while (busy !== lvl && n < max) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, busy, lvl);
    endtask

    // Cycles from a mid-cycle input change until busy is seen high.
    task automatic measure_latency(output int lat);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!busy && lat < 10);
    endtask

    task automatic pulse_force();
        @(negedge clock); force_req = 1'b1;
        @(negedge clock); force_req = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  ctrl;
        logic [6:0]  lpf;
        logic [5:0]  hpf;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat, bc, r0, f0, n;

        vecs[0] = '{3'b101, 7'h40, 6'b000001, 16'hB001};
        vecs[1] = '{3'b010, 7'h08, 6'b000100, 16'h4204};
        vecs[2] = '{3'b111, 7'h7F, 6'b111111, 16'hFFFF};
        vecs[3] = '{3'b000, 7'h00, 6'b000000, 16'h0000};
        vecs[4] = '{3'b001, 7'h02, 6'b010000, 16'h2090};

        hpf = 6'b100000; lpf = 7'h01; ctrl = 3'b000; force_req = 1'b0;
        tick(3);
        check("reset_outputs", {spi_clk, spi_data, spi_load, busy}, 4'b0000);

        // First frame after reset release.
        @(negedge clock); reset_n = 1'b1;
        exp_q.push_back(16'h0060);
        measure_latency(lat);
        check("reset_start_latency", lat, 2);
        bc = 1;
        while (busy && bc < 400) begin
            @(posedge clock); #1;
            if (busy) bc++;
        end
        check("busy_length", bc, FRAME_CYCLES);
        tick(2);
        check("first_frame_count", frames_rx, 1);

        // Steady inputs: no further activity.
        r0 = clk_rises;
        tick(1000);
        check("steady_clk_edges", clk_rises, r0);
        check("steady_busy", busy, 1'b0);
        check("steady_frames", frames_rx, 1);

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            f0 = frames_rx;
            @(negedge clock);
            ctrl = vecs[i].ctrl; lpf = vecs[i].lpf; hpf = vecs[i].hpf;
            exp_q.push_back(vecs[i].exp);
            wait_busy(1'b1, 10, "vec_start");
            wait_busy(1'b0, 200, "vec_end");
            tick(2);
            check("vec_frame_count", frames_rx, f0 + 1);
        end

        // HPF 010000 -> 000001: busy two cycles after the change.
        f0 = frames_rx;
        @(negedge clock); hpf = 6'b000001;
        exp_q.push_back(16'h2081);
        measure_latency(lat);
        check("hpf_start_latency", lat, 2);
        wait_busy(1'b0, 200, "hpf_end");
        tick(2);
        check("hpf_frame_count", frames_rx, f0 + 1);

        // Two changes mid-frame collapse into one resend of the latest value.
        f0 = frames_rx;
        @(negedge clock); ctrl = 3'b000; lpf = 7'h01; hpf = 6'b100000;
        exp_q.push_back(16'h0060);
        wait_busy(1'b1, 10, "dbl_start");
        tick(40);
        @(negedge clock); hpf = 6'b001000;
        tick(40);
        @(negedge clock); hpf = 6'b000100;
        exp_q.push_back(16'h0044);
        wait_busy(1'b0, 200, "dbl_first_end");
        wait_busy(1'b1, 10, "dbl_resend_start");
        wait_busy(1'b0, 200, "dbl_resend_end");
        tick(300);
        check("dbl_frame_count", frames_rx, f0 + 2);

        // force in IDLE: one identical frame.
        f0 = frames_rx;
        pulse_force();
        exp_q.push_back(16'h0044);
        wait_busy(1'b1, 10, "force_idle_start");
        wait_busy(1'b0, 200, "force_idle_end");
        tick(300);
        check("force_idle_count", frames_rx, f0 + 1);

        // force while busy: ignored.
        f0 = frames_rx;
        pulse_force();
        exp_q.push_back(16'h0044);
        wait_busy(1'b1, 10, "force_busy_start");
        tick(20);
        pulse_force();
        wait_busy(1'b0, 200, "force_busy_end");
        tick(300);
        check("force_busy_count", frames_rx, f0 + 1);
        check("force_busy_idle", busy, 1'b0);

        // Reset asserted at bit 7 of a frame (0xC0C2: bit 7 is a one).
        f0 = frames_rx;
        @(negedge clock); ctrl = 3'b110; lpf = 7'h03; hpf = 6'b000010;
        wait_busy(1'b1, 10, "rst_frame_start");
        n = 0;
        while (nbits < 8 && n < 200) begin tick(1); n++; end
        n = 0;
        while (spi_clk && n < 20) begin tick(1); n++; end
        tick(1);
        check("bit7_data_before_reset", {spi_clk, spi_data, busy}, 3'b011);
        #3 reset_n = 1'b0;
        #1 check("midframe_reset_outputs", {spi_clk, spi_data, spi_load, busy}, 4'b0000);
        tick(3);
        @(negedge clock); reset_n = 1'b1;
        exp_q.push_back(16'hC0C2);
        wait_busy(1'b1, 10, "rst_resend_start");
        wait_busy(1'b0, 200, "rst_resend_end");
        tick(300);
        check("rst_frame_count", frames_rx, f0 + 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
